// File: rtl/result_arb_pkg.sv
// Shared constants, ID width helper and result word type for result_reg_arbiter.
package result_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 4;
  localparam int unsigned DEF_DATA_W  = 32;

  // Source-ID width: clog2 of the requester count, never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef logic [DEF_DATA_W-1:0] result_word_t;

endpackage

// File: rtl/result_reg_arbiter_if.sv
// Request and result handshake bundle for result_reg_arbiter.
// Optional out_parity exists only when RESULT_ARB_PARITY_EN is defined.
interface result_reg_arbiter_if
  import result_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W
);
  localparam int unsigned ID_W = id_width(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic [ID_W-1:0]           out_src;
  logic                      out_ready;
`ifdef RESULT_ARB_PARITY_EN
  logic                      out_parity;
`endif

  // Requester/consumer side (drives requests and out_ready).
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src
`ifdef RESULT_ARB_PARITY_EN
    , input out_parity
`endif
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src
`ifdef RESULT_ARB_PARITY_EN
    , output out_parity
`endif
  );

endinterface

// File: rtl/result_reg_arbiter_rr_arbiter.sv
// Round-robin arbiter: pointer register, wrap-around priority search, one-hot grant.
module rr_arbiter
  import result_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_enable,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [ID_W-1:0]    o_grant_idx_c,
  output logic               o_any_grant_c
);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W-1:0] w_idx;
  logic            w_found;

  // First active request at or above the pointer, wrapping past NUM_REQ-1 to 0.
  always_comb begin
    int unsigned v_cand;
    logic [ID_W-1:0] v_sel;
    w_found = 1'b0;
    w_idx   = '0;
    v_cand  = 0;
    v_sel   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      v_cand = 32'(r_ptr) + off;
      if (v_cand >= NUM_REQ) v_cand = v_cand - NUM_REQ;
      v_sel = ID_W'(v_cand);
      if (!w_found && i_req[v_sel]) begin
        w_found = 1'b1;
        w_idx   = v_sel;
      end
    end
  end

  // One-hot grant only when the result slot can accept a word.
  always_comb begin
    o_grant_c     = '0;
    o_any_grant_c = w_found && i_enable;
    o_grant_idx_c = w_idx;
    if (o_any_grant_c) o_grant_c[w_idx] = 1'b1;
  end

  // Pointer moves one past the winner; held when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (o_any_grant_c) begin
      r_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/result_reg_arbiter.sv
// Shares one registered result slot among NUM_REQ requesters with round-robin arbitration.
// Define RESULT_ARB_PARITY_EN to add the registered out_parity output.
module result_reg_arbiter
  import result_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter  int unsigned DATA_W  = DEF_DATA_W,
  localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
  input logic                 clk,
  input logic                 reset,
  result_reg_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_any_grant;
  logic               w_can_load;
  logic [DATA_W-1:0]  w_sel_data;

  logic               r_out_valid;
  logic [DATA_W-1:0]  r_out_data;
  logic [ID_W-1:0]    r_out_src;

  assign w_can_load = !r_out_valid || bus.out_ready;
  assign w_sel_data = bus.req_data[w_grant_idx*DATA_W +: DATA_W];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clk          (clk),
    .reset        (reset),
    .i_req        (bus.req_valid),
    .i_enable     (w_can_load && !reset),
    .o_grant_c    (w_grant),
    .o_grant_idx_c(w_grant_idx),
    .o_any_grant_c(w_any_grant)
  );

  // Result register: load on grant, drop valid once delivered with no refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else if (w_any_grant) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_src   <= w_grant_idx;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef RESULT_ARB_PARITY_EN
  logic r_out_parity;

  // Even parity of the captured word, tracking out_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_parity <= 1'b0;
    end else if (w_any_grant) begin
      r_out_parity <= ^w_sel_data;
    end
  end

  assign bus.out_parity = r_out_parity;
`endif

  assign bus.req_ready = w_grant;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;

endmodule

// File: tb/tb_result_reg_arbiter.sv
// Directed self-checking bench for result_reg_arbiter (NUM_REQ=4, DATA_W=32).
module tb_result_reg_arbiter;
  import result_arb_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  result_reg_arbiter_if #(.NUM_REQ(4), .DATA_W(32)) bus ();

  result_reg_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int idx, input result_word_t w);
    bus.req_data[idx*32 +: 32] = w;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.req_valid = 4'b1111;
    bus.req_data  = '0;
    bus.out_ready = 1'b1;

    // Reset held two cycles with every requester active
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
      chk("rst_out_data",  64'(bus.out_data),  64'h0);
      chk("rst_out_src",   64'(bus.out_src),   64'h0);
    end
    reset = 1'b0;
    bus.req_valid = 4'b0000;

    // Single requester 2
    tick();
    bus.req_valid = 4'b0100;
    set_data(2, 32'hDEADBEEF);
    #1;
    chk("single_req_ready", 64'(bus.req_ready), 64'h4);
    tick();
    chk("single_out_valid", 64'(bus.out_valid), 64'h1);
    chk("single_out_data",  64'(bus.out_data),  64'hDEADBEEF);
    chk("single_out_src",   64'(bus.out_src),   64'h2);
    bus.req_valid = 4'b0000;
    tick();
    chk("drain_out_valid", 64'(bus.out_valid), 64'h0);
    chk("drain_data_hold", 64'(bus.out_data),  64'hDEADBEEF);
    chk("drain_src_hold",  64'(bus.out_src),   64'h2);

    // Pointer back to 0, then fairness with all four active
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_data(i, 32'(32'h10 + i));
    bus.req_valid = 4'b1111;
    for (int s = 0; s < 6; s++) begin
      #1;
      chk("fair_req_ready", 64'(bus.req_ready), 64'(4'b0001 << (s % 4)));
      tick();
      chk("fair_out_valid", 64'(bus.out_valid), 64'h1);
      chk("fair_out_src",   64'(bus.out_src),   64'(s % 4));
      chk("fair_out_data",  64'(bus.out_data),  64'(32'h10 + (s % 4)));
    end
    // Pointer is now 2

    // Backpressure: load A5A5A5A5 from requester 0
    bus.req_valid = 4'b0001;
    set_data(0, 32'hA5A5A5A5);
    #1;
    chk("bp_load_ready", 64'(bus.req_ready), 64'h1);
    tick();
    chk("bp_load_data", 64'(bus.out_data), 64'hA5A5A5A5);
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0110;
    set_data(1, 32'h11111111);
    set_data(2, 32'h22222222);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_req_ready", 64'(bus.req_ready), 64'h0);
      tick();
      chk("bp_out_valid", 64'(bus.out_valid), 64'h1);
      chk("bp_out_data",  64'(bus.out_data),  64'hA5A5A5A5);
      chk("bp_out_src",   64'(bus.out_src),   64'h0);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(bus.req_ready), 64'h2);
    tick();
    chk("bp_release_data", 64'(bus.out_data), 64'h11111111);
    chk("bp_release_src",  64'(bus.out_src),  64'h1);
    // Pointer is now 2, out_valid=1

    // Reset mid-operation with requesters 0 and 3 active
    bus.req_valid = 4'b1001;
    reset = 1'b1;
    #1;
    chk("midrst_req_ready", 64'(bus.req_ready), 64'h0);
    tick();
    chk("midrst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("midrst_out_data",  64'(bus.out_data),  64'h0);
    reset = 1'b0;
    #1;
    chk("midrst_grant", 64'(bus.req_ready), 64'h1);
    tick();
    chk("midrst_out_src",  64'(bus.out_src),  64'h0);
    chk("midrst_out_data2", 64'(bus.out_data), 64'hA5A5A5A5);

    // Withdraw before grant: requester 2 drops while stalled, pointer stays at 1
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = 4'b1000;
    bus.out_ready = 1'b1;
    set_data(3, 32'h33333333);
    #1;
    chk("wd_req_ready", 64'(bus.req_ready), 64'h8);
    tick();
    chk("wd_out_src", 64'(bus.out_src), 64'h3);

`ifdef RESULT_ARB_PARITY_EN
    // Parity of two captured words
    bus.req_valid = 4'b0001;
    set_data(0, 32'h00000007);
    tick();
    chk("parity_7", 64'(bus.out_parity), 64'h1);
    set_data(0, 32'h00000003);
    tick();
    chk("parity_3", 64'(bus.out_parity), 64'h0);
`endif

    bus.req_valid = 4'b0000;
    tick();
    chk("final_out_valid", 64'(bus.out_valid), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_reg_arbiter.md
Name: result_reg_arbiter

Overview:
- Shares one DATA_W-bit registered result slot between NUM_REQ requesters using round-robin arbitration.
- Each requester offers a word with a valid/ready handshake. The winner's word is latched into the result register and presented downstream with its source ID under a valid/ready handshake.
- Sits between the compute lanes and the single result register / writeback path.

Parameters:
- NUM_REQ, 4, number of requesters (>=1).
- DATA_W, 32, result word width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_data  input  NUM_REQ*DATA_W  flattened request data; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  output  NUM_REQ  one-hot grant; requester i's word is accepted this cycle.
- out_valid  output  1  result register holds an undelivered word.
- out_data  output  DATA_W  registered result word.
- out_src  output  ID_W  index of the requester that produced out_data; ID_W = max(1, clog2(NUM_REQ)).
- out_ready  input  1  downstream accepts out_data this cycle.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_src=0, RR pointer=0, req_ready=0 while reset is high.
- can_load = !out_valid || out_ready.
  - req_ready is combinational and one-hot, and is asserted only when can_load=1 and at least one req_valid=1.
  - All req_ready bits are 0 when can_load=0.
- Winner selection:
  - The winner is the first requester with req_valid=1, searching upward from the RR pointer with wrap-around (pointer, pointer+1, ..., NUM_REQ-1, 0, ...).
- On a grant to requester k, at the next edge:
  - out_data <= req_data[k]
  - out_src <= k
  - out_valid <= 1
  - pointer <= (k+1) mod NUM_REQ
- With no grant:
  - pointer is held.
  - If out_valid && out_ready, out_valid <= 0.
  - out_data and out_src hold their last values; they are never cleared except by reset.
- Latency: 1 cycle from grant to out_valid.
- Throughput: one word per cycle while out_ready=1. Drain and refill happen in the same cycle with no bubble.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_src are stable and no requester is granted.
- Requester rules:
  - After asserting req_valid, a requester holds req_valid and its data stable until req_ready.
  - Withdrawing before grant is tolerated; the pointer is unaffected.
- NUM_REQ=1: requester 0 is always the winner and out_src is constantly 0.
- Reset mid-operation: a pending output word is discarded, out_valid=0 on the next cycle, and the pointer returns to 0. No grant is issued in a reset cycle.

Optional Feature:
- Macro: RESULT_ARB_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = even-parity XOR-reduction of the captured word.
  - It is registered in the same cycle as out_data, resets to 0, and holds with out_data.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package result_arb_pkg holds:
  - default DATA_W and NUM_REQ constants.
  - ID_W computation function (max(1,clog2)).
  - typedef for the DATA_W result word.
- One sub-module: rr_arbiter.
  - Contains the RR pointer register, wrap-around priority search and one-hot grant generation.
  - Inputs: req, enable (=can_load).
  - Outputs: grant one-hot, grant index, any-grant.
- The top level holds the result register, out_valid logic, data mux and the optional parity.

Test Plan:
- Reset:
  - Stimulus: assert reset 2 cycles with req_valid=4'b1111 and out_ready=1.
  - Response: req_ready=0, out_valid=0, out_data=0, out_src=0 throughout.
- Single requester:
  - Stimulus: req_valid=4'b0100, req_data[2]=32'hDEADBEEF, out_ready=1.
  - Response: req_ready=4'b0100 in the same cycle; next cycle out_valid=1, out_data=32'hDEADBEEF, out_src=2.
- Fairness:
  - Stimulus: all four requesters hold valid continuously with data 32'h10+i; out_ready=1.
  - Response: out_src sequence is 0,1,2,3,0,1 on consecutive cycles with no bubbles.
- Backpressure:
  - Stimulus: out_ready=0 after the first word (32'hA5A5A5A5) is loaded.
  - Response while out_ready=0: req_ready=0 and out_data stable for 5 cycles.
  - Stimulus: raise out_ready.
  - Response: the next requester is granted in the same cycle and the new word appears 1 cycle later.
- Reset mid-operation:
  - Stimulus: out_valid=1, pointer=2, req_valid=4'b1001; pulse reset for 1 cycle.
  - Response: out_valid=0 after reset; the first grant afterwards goes to requester 0, not 3.
- Parity (with RESULT_ARB_PARITY_EN):
  - Stimulus: load 32'h00000007, then 32'h00000003.
  - Response: out_parity=1, then 0.
